// File: rtl/mcr_rom_loader_pkg.sv
// Shared types for the MCR2 ROM loader: engine states, buffered byte entries
// and the sprite-port address remap.
package mcr_loader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    typedef struct packed {
        logic [24:0] addr;
        logic [7:0]  data;
    } fifo_entry_t;

    typedef struct packed {
        logic [22:0] a;
        logic [1:0]  ds;
    } port_cmd_t;

    // The sprite ROM sits behind a 32-bit port; bit 15 of the offset picks the
    // 16-bit half and bit 14 the byte lane.
    function automatic port_cmd_t sprite_remap(input logic [23:0] s);
        port_cmd_t c;
        c.a  = {s[23:16], s[13:0], s[15]};
        c.ds = {s[14], ~s[14]};
        return c;
    endfunction

endpackage

// File: rtl/mcr_rom_loader_if.sv
// The two SDRAM write ports driven by the loader, each with a toggle req/ack.
interface mcr_rom_loader_if;
    logic        port1_req;
    logic        port1_ack;
    logic [22:0] port1_a;
    logic [1:0]  port1_ds;
    logic [15:0] port1_d;
    logic        port1_we;

    logic        port2_req;
    logic        port2_ack;
    logic [22:0] port2_a;
    logic [1:0]  port2_ds;
    logic [15:0] port2_d;
    logic        port2_we;

    modport master (
        output port1_req, port1_a, port1_ds, port1_d, port1_we,
        output port2_req, port2_a, port2_ds, port2_d, port2_we,
        input  port1_ack, port2_ack
    );

    modport slave (
        input  port1_req, port1_a, port1_ds, port1_d, port1_we,
        input  port2_req, port2_a, port2_ds, port2_d, port2_we,
        output port1_ack, port2_ack
    );
endinterface

// File: rtl/mcr_rom_loader_fifo.sv
// Small synchronous FIFO of download bytes; head is read combinationally.
module mcr_loader_fifo
    import mcr_loader_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        push_i,
    input  logic        pop_i,
    input  fifo_entry_t wdata_i,
    output fifo_entry_t rdata_o,
    output logic        full_o,
    output logic        empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    fifo_entry_t   mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/mcr_rom_loader.sv
// Sequences data_io ROM download bytes into the SDRAM write ports and generates
// the ROM-loaded flag plus the core reset sequence for the MCR2 cores.
module mcr_rom_loader
    import mcr_loader_pkg::*;
#(
    parameter logic [24:0] SP_BASE      = 25'h12000,
    parameter int          FIFO_DEPTH   = 4,
    parameter logic [15:0] RESET_CYCLES = 16'hFFFF
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ioctl_downl,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic        user_reset,
    mcr_rom_loader_if.master sdram,
    output logic        busy,
    output logic        rom_loaded,
    output logic        core_reset,
    output logic        overflow
);

    state_t      state_q, state_d;
    logic        wr_prev_q, downl_prev_q;
    logic        push_req, push, pop;
    logic        fifo_full, fifo_empty;
    fifo_entry_t push_entry, head;
    logic        acks_match;
    logic        sp_hit;
    logic [23:0] sp_off;
    port_cmd_t   sp_cmd;

    logic        p2_hit_q;
    logic        port1_req_q, port2_req_q;
    logic [22:0] port1_a_q, port2_a_q;
    logic [1:0]  port1_ds_q, port2_ds_q;
    logic [15:0] port1_d_q, port2_d_q;

    logic        done_pend_q, rom_loaded_q, overflow_q, core_reset_q;
    logic [15:0] count_q;

    assign push_req   = ioctl_wr & ~wr_prev_q & ioctl_downl & (ioctl_index == 8'd0);
    assign push       = push_req & (~fifo_full | pop);
    assign push_entry = '{addr: ioctl_addr, data: ioctl_dout};

    mcr_loader_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_sys),
        .rst_ni  (reset_n),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (push_entry),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign sp_hit     = (head.addr >= SP_BASE);
    assign sp_off     = 24'(head.addr - SP_BASE);
    assign sp_cmd     = sprite_remap(sp_off);
    assign acks_match = (sdram.port1_ack == port1_req_q) &&
                        (!p2_hit_q || (sdram.port2_ack == port2_req_q));

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE:   state_d = WAIT;
            WAIT: begin
                if (acks_match) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Command registers load on pop so they are stable through ISSUE and WAIT.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            p2_hit_q    <= 1'b0;
            port1_req_q <= 1'b0;
            port2_req_q <= 1'b0;
            port1_a_q   <= '0;
            port1_ds_q  <= '0;
            port1_d_q   <= '0;
            port2_a_q   <= '0;
            port2_ds_q  <= '0;
            port2_d_q   <= '0;
        end else begin
            if (pop) begin
                p2_hit_q   <= sp_hit;
                port1_a_q  <= head.addr[23:1];
                port1_ds_q <= {head.addr[0], ~head.addr[0]};
                port1_d_q  <= {head.data, head.data};
                if (sp_hit) begin
                    port2_a_q  <= sp_cmd.a;
                    port2_ds_q <= sp_cmd.ds;
                    port2_d_q  <= {head.data, head.data};
                end
            end
            if (state_q == ISSUE) begin
                port1_req_q <= ~port1_req_q;
                if (p2_hit_q) begin
                    port2_req_q <= ~port2_req_q;
                end
            end
        end
    end

    assign busy = ioctl_downl | ~fifo_empty | (state_q != IDLE);

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            wr_prev_q    <= 1'b0;
            downl_prev_q <= 1'b0;
            done_pend_q  <= 1'b0;
            rom_loaded_q <= 1'b0;
            overflow_q   <= 1'b0;
            count_q      <= RESET_CYCLES;
            core_reset_q <= 1'b1;
        end else begin
            wr_prev_q    <= ioctl_wr;
            downl_prev_q <= ioctl_downl;
            if (push_req && fifo_full && !pop) begin
                overflow_q <= 1'b1;
            end
            if (downl_prev_q && !ioctl_downl) begin
                done_pend_q <= 1'b1;
            end else if (done_pend_q && !busy) begin
                done_pend_q  <= 1'b0;
                rom_loaded_q <= 1'b1;
            end
            // Counting down to 1 after the first reset release fires the second pulse.
            if (user_reset || !rom_loaded_q) begin
                count_q <= RESET_CYCLES;
            end else if (count_q != 16'd0) begin
                count_q <= count_q - 16'd1;
            end
            core_reset_q <= user_reset | ~rom_loaded_q | (count_q == 16'd1);
        end
    end

    assign rom_loaded = rom_loaded_q;
    assign overflow   = overflow_q;
    assign core_reset = core_reset_q;

    assign sdram.port1_req = port1_req_q;
    assign sdram.port1_a   = port1_a_q;
    assign sdram.port1_ds  = port1_ds_q;
    assign sdram.port1_d   = port1_d_q;
    assign sdram.port1_we  = ioctl_downl | busy;
    assign sdram.port2_req = port2_req_q;
    assign sdram.port2_a   = port2_a_q;
    assign sdram.port2_ds  = port2_ds_q;
    assign sdram.port2_d   = port2_d_q;
    assign sdram.port2_we  = ioctl_downl | busy;

endmodule

// File: tb/tb_mcr_rom_loader.sv
// Directed bench for mcr_rom_loader: the bench plays data_io and the SDRAM
// ack side, with expected values worked out by hand.
module tb_mcr_rom_loader;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ioctl_downl;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        user_reset;
    logic        busy, rom_loaded, core_reset, overflow;

    int checks = 0;
    int errors = 0;
    logic exp_req1 = 1'b0;
    logic exp_req2 = 1'b0;

    mcr_rom_loader_if bif ();

    mcr_rom_loader #(
        .SP_BASE      (25'h12000),
        .FIFO_DEPTH   (4),
        .RESET_CYCLES (16'd16)
    ) dut (
        .clk_sys     (clk),
        .reset_n     (reset_n),
        .ioctl_downl (ioctl_downl),
        .ioctl_index (ioctl_index),
        .ioctl_wr    (ioctl_wr),
        .ioctl_addr  (ioctl_addr),
        .ioctl_dout  (ioctl_dout),
        .user_reset  (user_reset),
        .sdram       (bif),
        .busy        (busy),
        .rom_loaded  (rom_loaded),
        .core_reset  (core_reset),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic strobe(input logic [24:0] a, input logic [7:0] d, input logic [7:0] idx);
        @(negedge clk);
        ioctl_addr  = a;
        ioctl_dout  = d;
        ioctl_index = idx;
        ioctl_wr    = 1'b1;
        @(negedge clk);
        ioctl_wr    = 1'b0;
    endtask

    task automatic wait_req(input int port, input logic want, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (((port == 1) ? bif.port1_req : bif.port2_req) === want) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n       = 1'b0;
        ioctl_downl   = 1'b0;
        ioctl_index   = 8'd0;
        ioctl_wr      = 1'b0;
        ioctl_addr    = '0;
        ioctl_dout    = '0;
        user_reset    = 1'b0;
        bif.port1_ack = 1'b0;
        bif.port2_ack = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (core_reset !== 1'b1) begin errors++; $display("[TB] FAIL reset_core_reset: got %b want 1", core_reset); end
        checks++; if (rom_loaded !== 1'b0) begin errors++; $display("[TB] FAIL reset_rom_loaded: got %b want 0", rom_loaded); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        checks++; if (bif.port1_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req1: got %b want 0", bif.port1_req); end
        checks++; if (bif.port2_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req2: got %b want 0", bif.port2_req); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow: got %b want 0", overflow); end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_main_byte();
        bit ok;
        ioctl_downl = 1'b1;
        strobe(25'h00003, 8'hA5, 8'd0);
        exp_req1 = ~exp_req1;
        wait_req(1, exp_req1, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL main_req1_toggle: got %b want %b", bif.port1_req, exp_req1); end
        checks++; if (bif.port1_a !== 23'h000001) begin errors++; $display("[TB] FAIL main_p1_a: got %h want 000001", bif.port1_a); end
        checks++; if (bif.port1_ds !== 2'b10) begin errors++; $display("[TB] FAIL main_p1_ds: got %b want 10", bif.port1_ds); end
        checks++; if (bif.port1_d !== 16'hA5A5) begin errors++; $display("[TB] FAIL main_p1_d: got %h want a5a5", bif.port1_d); end
        checks++; if (bif.port1_we !== 1'b1) begin errors++; $display("[TB] FAIL main_p1_we: got %b want 1", bif.port1_we); end
        repeat (5) @(negedge clk);
        bif.port1_ack = exp_req1;
        repeat (4) @(negedge clk);
        checks++; if (bif.port1_req !== exp_req1) begin errors++; $display("[TB] FAIL main_req1_once: got %b want %b", bif.port1_req, exp_req1); end
        checks++; if (bif.port2_req !== exp_req2) begin errors++; $display("[TB] FAIL main_req2_quiet: got %b want %b", bif.port2_req, exp_req2); end
    endtask

    task automatic test_sprite_byte();
        bit ok;
        strobe(25'h16001, 8'h3C, 8'd0);
        exp_req1 = ~exp_req1;
        exp_req2 = ~exp_req2;
        wait_req(2, exp_req2, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL sprite_req2_toggle: got %b want %b", bif.port2_req, exp_req2); end
        checks++; if (bif.port1_req !== exp_req1) begin errors++; $display("[TB] FAIL sprite_req1_toggle: got %b want %b", bif.port1_req, exp_req1); end
        checks++; if (bif.port2_a !== 23'h000002) begin errors++; $display("[TB] FAIL sprite_p2_a: got %h want 000002", bif.port2_a); end
        checks++; if (bif.port2_ds !== 2'b10) begin errors++; $display("[TB] FAIL sprite_p2_ds: got %b want 10", bif.port2_ds); end
        checks++; if (bif.port2_d !== 16'h3C3C) begin errors++; $display("[TB] FAIL sprite_p2_d: got %h want 3c3c", bif.port2_d); end
        checks++; if (bif.port1_a !== 23'h00B000) begin errors++; $display("[TB] FAIL sprite_p1_a: got %h want 00b000", bif.port1_a); end
        bif.port1_ack = exp_req1;
        strobe(25'h00010, 8'h11, 8'd0);
        repeat (6) @(negedge clk);
        checks++; if (bif.port1_req !== exp_req1) begin errors++; $display("[TB] FAIL sprite_hold_for_ack2: got %b want %b", bif.port1_req, exp_req1); end
        bif.port2_ack = exp_req2;
        exp_req1 = ~exp_req1;
        wait_req(1, exp_req1, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL sprite_next_issue: got %b want %b", bif.port1_req, exp_req1); end
        checks++; if (bif.port1_d !== 16'h1111) begin errors++; $display("[TB] FAIL sprite_next_d: got %h want 1111", bif.port1_d); end
        checks++; if (bif.port2_req !== exp_req2) begin errors++; $display("[TB] FAIL sprite_next_req2: got %b want %b", bif.port2_req, exp_req2); end
        bif.port1_ack = exp_req1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_overflow();
        bit ok;
        for (int i = 0; i < 6; i++) begin
            strobe(25'h00020 + 25'(i), 8'h60 + 8'(i), 8'd0);
            if (i == 4) begin
                checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL ovf_early: got %b want 0", overflow); end
            end
        end
        checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_flag: got %b want 1", overflow); end
        exp_req1 = ~exp_req1;
        checks++; if (bif.port1_req !== exp_req1) begin errors++; $display("[TB] FAIL ovf_in_flight: got %b want %b", bif.port1_req, exp_req1); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bif.port1_d !== {8'h60 + 8'(i), 8'h60 + 8'(i)}) begin
                errors++;
                $display("[TB] FAIL ovf_drain_d%0d: got %h want %h", i, bif.port1_d, {8'h60 + 8'(i), 8'h60 + 8'(i)});
            end
            bif.port1_ack = exp_req1;
            if (i < 4) begin
                exp_req1 = ~exp_req1;
                wait_req(1, exp_req1, ok);
                checks++; if (!ok) begin errors++; $display("[TB] FAIL ovf_drain_req%0d: got %b want %b", i, bif.port1_req, exp_req1); end
            end
        end
        repeat (8) @(negedge clk);
        checks++; if (bif.port1_req !== exp_req1) begin errors++; $display("[TB] FAIL ovf_sixth_dropped: got %b want %b", bif.port1_req, exp_req1); end
    endtask

    task automatic test_done();
        bit ok;
        bit bad;
        strobe(25'h00030, 8'h77, 8'd0);
        strobe(25'h00031, 8'h78, 8'd0);
        @(negedge clk);
        ioctl_downl = 1'b0;
        exp_req1 = ~exp_req1;
        wait_req(1, exp_req1, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL done_first_issue: got %b want %b", bif.port1_req, exp_req1); end
        repeat (3) @(negedge clk);
        checks++; if (rom_loaded !== 1'b0) begin errors++; $display("[TB] FAIL done_early_first: got %b want 0", rom_loaded); end
        bif.port1_ack = exp_req1;
        exp_req1 = ~exp_req1;
        wait_req(1, exp_req1, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL done_second_issue: got %b want %b", bif.port1_req, exp_req1); end
        checks++; if (bif.port1_d !== 16'h7878) begin errors++; $display("[TB] FAIL done_second_d: got %h want 7878", bif.port1_d); end
        repeat (3) @(negedge clk);
        checks++; if (rom_loaded !== 1'b0) begin errors++; $display("[TB] FAIL done_early_second: got %b want 0", rom_loaded); end
        checks++; if (core_reset !== 1'b1) begin errors++; $display("[TB] FAIL done_core_reset_held: got %b want 1", core_reset); end
        bif.port1_ack = exp_req1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL done_busy_clear: got %b want 0", busy); end
        checks++; if (rom_loaded !== 1'b0) begin errors++; $display("[TB] FAIL done_loaded_too_soon: got %b want 0", rom_loaded); end
        @(negedge clk);
        checks++; if (rom_loaded !== 1'b1) begin errors++; $display("[TB] FAIL done_loaded: got %b want 1", rom_loaded); end
        checks++; if (core_reset !== 1'b1) begin errors++; $display("[TB] FAIL done_reset_still_high: got %b want 1", core_reset); end
        @(negedge clk);
        checks++; if (core_reset !== 1'b0) begin errors++; $display("[TB] FAIL done_reset_release: got %b want 0", core_reset); end
        bad = 1'b0;
        repeat (14) begin
            @(negedge clk);
            if (core_reset !== 1'b0) bad = 1'b1;
        end
        checks++; if (bad) begin errors++; $display("[TB] FAIL done_gap_low: got high want low"); end
        @(negedge clk);
        checks++; if (core_reset !== 1'b1) begin errors++; $display("[TB] FAIL done_second_pulse: got %b want 1", core_reset); end
        @(negedge clk);
        checks++; if (core_reset !== 1'b0) begin errors++; $display("[TB] FAIL done_pulse_width: got %b want 0", core_reset); end
    endtask

    task automatic test_non_rom();
        @(negedge clk);
        ioctl_downl = 1'b1;
        strobe(25'h00005, 8'hEE, 8'hFF);
        repeat (6) @(negedge clk);
        checks++; if (bif.port1_req !== exp_req1) begin errors++; $display("[TB] FAIL nonrom_req1: got %b want %b", bif.port1_req, exp_req1); end
        checks++; if (bif.port1_d !== 16'h7878) begin errors++; $display("[TB] FAIL nonrom_d: got %h want 7878", bif.port1_d); end
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL nonrom_busy_dl: got %b want 1", busy); end
        ioctl_downl = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL nonrom_busy_idle: got %b want 0", busy); end
        checks++; if (bif.port1_we !== 1'b0) begin errors++; $display("[TB] FAIL nonrom_we: got %b want 0", bif.port1_we); end
        checks++; if (rom_loaded !== 1'b1) begin errors++; $display("[TB] FAIL nonrom_loaded_sticky: got %b want 1", rom_loaded); end
    endtask

    initial begin
        $display("[TB] mcr_rom_loader directed bench");
        test_reset();
        test_main_byte();
        test_sprite_byte();
        test_overflow();
        test_done();
        test_non_rom();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
